// File: rtl/traffic_light_monitor_if.sv
// ============================================================================
// traffic_light_monitor_if -- lamp-drive observation and status bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface traffic_light_monitor_if #(
  parameter int MAX_DWELL = 16,
  parameter int CNT_W     = 8
);
  localparam int DW = $clog2(MAX_DWELL + 1);

  logic             light_r;
  logic             light_y;
  logic             light_g;
  logic             clr_fault;
  logic [1:0]       phase;
  logic             phase_valid;
  logic [DW-1:0]    dwell_cnt;
  logic [CNT_W-1:0] cycle_count;
  logic             fault;
  logic             seq_err;
  logic             pattern_err;
  logic             dwell_err;

  modport master (
    output light_r, light_y, light_g, clr_fault,
    input  phase, phase_valid, dwell_cnt, cycle_count,
    input  fault, seq_err, pattern_err, dwell_err
  );

  modport slave (
    input  light_r, light_y, light_g, clr_fault,
    output phase, phase_valid, dwell_cnt, cycle_count,
    output fault, seq_err, pattern_err, dwell_err
  );
endinterface

`default_nettype wire

// File: rtl/traffic_light_monitor.sv
// ============================================================================
// traffic_light_monitor -- passive phase-order / dwell checker on lamp drives
// Rev 1.0
// ============================================================================
`default_nettype none

module traffic_light_monitor #(
  parameter int MAX_DWELL = 16,
  parameter int CNT_W     = 8
) (
  input  logic                     timer_clk,
  input  logic                     rst,
  traffic_light_monitor_if.slave   mon
);
  localparam int DW = $clog2(MAX_DWELL + 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_TRACK = 2'd1;
  localparam logic [1:0] c_FAULT = 2'd2;

  localparam logic [1:0] c_RED = 2'd0;
  localparam logic [1:0] c_YEL = 2'd3;

  localparam logic [DW-1:0]    c_DWELL_MAX = DW'(MAX_DWELL);
  localparam logic [DW-1:0]    c_DWELL_ONE = DW'(1);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic             valid_q, valid_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic             fault_q, fault_d;
  logic             seq_q, seq_d;
  logic             pat_q, pat_d;
  logic             dwl_q, dwl_d;

  logic       w_is_phase;
  logic       w_is_dark;
  logic       w_illegal;
  logic [1:0] w_in_phase;
  logic       w_same;
  logic       w_next;
  logic       w_dwell_hit;
  logic       w_enter_red;

  always_comb begin
    w_is_phase = 1'b0;
    w_is_dark  = 1'b0;
    w_in_phase = 2'd0;
    case ({mon.light_r, mon.light_y, mon.light_g})
      3'b100: begin w_is_phase = 1'b1; w_in_phase = 2'd0; end
      3'b110: begin w_is_phase = 1'b1; w_in_phase = 2'd1; end
      3'b001: begin w_is_phase = 1'b1; w_in_phase = 2'd2; end
      3'b010: begin w_is_phase = 1'b1; w_in_phase = 2'd3; end
      3'b000: w_is_dark = 1'b1;
      default: ;
    endcase
  end

  assign w_illegal   = !w_is_phase && !w_is_dark;
  assign w_same      = w_is_phase && (w_in_phase == phase_q);
  assign w_next      = w_is_phase && (w_in_phase == (phase_q + 2'd1));
  assign w_dwell_hit = (dwell_q == c_DWELL_MAX);
  assign w_enter_red = w_is_phase && (w_in_phase == c_RED);

  always_ff @(posedge timer_clk or posedge rst) begin
    if (rst) begin
      state_q <= c_IDLE;
      phase_q <= 2'd0;
      valid_q <= 1'b0;
      dwell_q <= '0;
      cycle_q <= '0;
      fault_q <= 1'b0;
      seq_q   <= 1'b0;
      pat_q   <= 1'b0;
      dwl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
      dwell_q <= dwell_d;
      cycle_q <= cycle_d;
      fault_q <= fault_d;
      seq_q   <= seq_d;
      pat_q   <= pat_d;
      dwl_q   <= dwl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (w_enter_red)    state_d = c_TRACK;
        else if (w_illegal) state_d = c_FAULT;
      end
      c_TRACK: begin
        if (!w_is_phase)                state_d = c_FAULT;
        else if (w_same && w_dwell_hit) state_d = c_FAULT;
        else if (!w_same && !w_next)    state_d = c_FAULT;
      end
      c_FAULT: begin
        if (mon.clr_fault) state_d = c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
  end

  // Each fault entry raises exactly one flag; the branch order encodes priority.
  always_comb begin
    phase_d = phase_q;
    valid_d = valid_q;
    dwell_d = dwell_q;
    cycle_d = cycle_q;
    fault_d = fault_q;
    seq_d   = seq_q;
    pat_d   = pat_q;
    dwl_d   = dwl_q;
    case (state_q)
      c_IDLE: begin
        if (w_enter_red) begin
          phase_d = c_RED;
          valid_d = 1'b1;
          dwell_d = c_DWELL_ONE;
        end else if (w_illegal) begin
          fault_d = 1'b1;
          pat_d   = 1'b1;
        end
      end
      c_TRACK: begin
        if (!w_is_phase) begin
          valid_d = 1'b0;
          fault_d = 1'b1;
          pat_d   = 1'b1;
        end else if (w_same) begin
          if (w_dwell_hit) begin
            valid_d = 1'b0;
            fault_d = 1'b1;
            dwl_d   = 1'b1;
          end else begin
            dwell_d = dwell_q + c_DWELL_ONE;
          end
        end else if (w_next) begin
          phase_d = w_in_phase;
          dwell_d = c_DWELL_ONE;
          if (phase_q == c_YEL) cycle_d = cycle_q + c_CNT_ONE;
        end else begin
          valid_d = 1'b0;
          fault_d = 1'b1;
          seq_d   = 1'b1;
        end
      end
      c_FAULT: begin
        if (mon.clr_fault) begin
          fault_d = 1'b0;
          seq_d   = 1'b0;
          pat_d   = 1'b0;
          dwl_d   = 1'b0;
          dwell_d = '0;
        end
      end
      default: begin
        valid_d = 1'b0;
        fault_d = 1'b0;
      end
    endcase
  end

  assign mon.phase       = phase_q;
  assign mon.phase_valid = valid_q;
  assign mon.dwell_cnt   = dwell_q;
  assign mon.cycle_count = cycle_q;
  assign mon.fault       = fault_q;
  assign mon.seq_err     = seq_q;
  assign mon.pattern_err = pat_q;
  assign mon.dwell_err   = dwl_q;

endmodule

`default_nettype wire

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the lamp-drive interface of the traffic light controller.
- Watches the red, yellow and green lamp lines and decodes them back into a phase.
- Checks for legal phase order and per-phase dwell limits, and counts completed light cycles.
- Sits beside the controller on the same timer_clk domain; intended for lamp-fault reporting and for bench self-checking.

Parameters:
- MAX_DWELL, 16: maximum consecutive cycles any phase may persist; must be >= 1.
- CNT_W, 8: width of the completed-cycle counter.
- DW (localparam), $clog2(MAX_DWELL+1): width of the dwell counter.

Ports:
- timer_clk  input  1  Block clock; all state updates on the rising edge.
- rst  input  1  Asynchronous, active-high reset.
- light_r  input  1  Red lamp drive, from a register in the timer_clk domain.
- light_y  input  1  Yellow lamp drive.
- light_g  input  1  Green lamp drive.
- clr_fault  input  1  Single-cycle pulse; exits FAULT and clears the error flags.
- phase  output  2  Decoded phase: 0=RED, 1=RED_YEL, 2=GREEN, 3=YEL.
- phase_valid  output  1  High while locked (TRACK state).
- dwell_cnt  output  DW  Consecutive cycles spent in the current phase.
- cycle_count  output  CNT_W  Completed full cycles (YEL->RED transitions); wraps.
- fault  output  1  High while in FAULT state.
- seq_err  output  1  Sticky flag: illegal phase order.
- pattern_err  output  1  Sticky flag: illegal or dark lamp pattern while locked.
- dwell_err  output  1  Sticky flag: dwell limit exceeded.

Behaviour:
- Reset value of every output is 0. State after reset is IDLE. Reset acts immediately, with no clock edge needed.
- Decode {r,y,g} combinationally from the raw inputs:
  - 100=RED, 110=RED_YEL, 001=GREEN, 010=YEL.
  - 000=DARK.
  - All other patterns (011, 101, 111) are ILLEGAL.
- All outputs are registered. An input sampled at edge k is reflected in the outputs after edge k.
- IDLE state:
  - DARK, RED_YEL, GREEN, YEL: stay in IDLE, no error.
  - RED: go to TRACK; phase<=0, phase_valid<=1, dwell_cnt<=1.
  - ILLEGAL: go to FAULT, pattern_err<=1.
- TRACK state:
  - Same phase: if dwell_cnt==MAX_DWELL, go to FAULT with dwell_err<=1 and dwell_cnt held. Otherwise dwell_cnt+1.
  - Next phase ((phase+1) mod 4): phase updates, dwell_cnt<=1. On YEL->RED, cycle_count+1, wrapping modulo 2^CNT_W.
  - Any other valid phase (skip or backward): go to FAULT, seq_err<=1.
  - DARK or ILLEGAL: go to FAULT, pattern_err<=1.
- On any entry to FAULT: phase_valid<=0, fault<=1; phase holds its last value.
  - Exactly one error flag is set per entry.
  - Priority is pattern_err > seq_err > dwell_err; the cases are mutually exclusive by construction.
- FAULT state:
  - Inputs are ignored and error flags remain sticky.
  - clr_fault=1: go to IDLE; fault, seq_err, pattern_err, dwell_err and dwell_cnt are cleared.
  - phase and cycle_count are preserved through clr_fault.
- clr_fault is ignored in IDLE and TRACK.
- cycle_count is cleared only by rst.
- rst asserted mid-operation: all outputs 0 immediately, state IDLE. Relock requires a RED sample after rst deasserts.

Test Plan:
- Nominal sequence:
  - Stimulus: rst, then 000 x2, then 100, 110, 001, 010, 100.
  - Response: phase_valid rises after the first 100 edge; phase steps 0,1,2,3,0 with dwell_cnt=1 each; cycle_count=1 after the final edge; all error flags 0.
- Skip in order:
  - Stimulus: lock on 100, then drive 001.
  - Response: next edge fault=1, seq_err=1, phase_valid=0, phase=0. Further inputs leave all outputs unchanged.
- Illegal pattern and clear:
  - Stimulus: in TRACK drive 101, then pulse clr_fault.
  - Response: first pattern_err=1, fault=1. After clr_fault: IDLE, flags 0, dwell_cnt=0, cycle_count unchanged. Then 110 keeps IDLE and 100 relocks.
- Dwell limit (MAX_DWELL=4):
  - Stimulus: hold 100 for 4 cycles, then a 5th cycle.
  - Response: after 4 cycles dwell_cnt=4 with no error. On the 5th, dwell_err=1, fault=1, dwell_cnt=4.
- Asynchronous reset:
  - Stimulus: assert rst between edges while in TRACK with cycle_count=3.
  - Response: all outputs 0 before the next edge; after release, 010 is ignored and 100 locks.
- Counter wrap (CNT_W=2):
  - Stimulus: 4 full legal cycles.
  - Response: cycle_count goes 1,2,3,0 with no error flags set.
